mem_port_arbiter: RTL and testbench

//  Shares one single-port instruction/data memory between the fetch stage (read-only) and the memory stage (read/write).

---
 rtl/cpu_pkg.sv | 14 +
 rtl/arb_sat_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the memory-port arbiter: FSM state, transaction owner,
// and a width helper for the saturating counters.
package cpu_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} arb_owner_e;

  // Bits needed to hold every value 0..maxVal (maxVal >= 1).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over
// increment); at_max flags that the count sits at MAX.
module arb_sat_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max
);

  assign at_max = (cnt == WIDTH'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch stage (read-only) and
// the memory stage, one outstanding transaction at a time, with timeout.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DAT_WIDTH   = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DAT_WIDTH-1:0]  i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DAT_WIDTH-1:0]  d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DAT_WIDTH-1:0]  d_rdata,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DAT_WIDTH-1:0]  mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DAT_WIDTH-1:0]  mem_rdata
);

  localparam int STARVE_W = cntWidth(STARVE_MAX);
  localparam int TMO_W    = cntWidth(TIMEOUT_CYC - 1);

  arb_state_e r_state, w_nextState;
  arb_owner_e r_owner, w_nextOwner;
  logic       r_ownerWe, w_nextOwnerWe;
  logic       r_errPend, w_nextErrPend;

  logic w_canGrant, w_fetchWins, w_done, w_timeout;
  logic w_starveAtMax, w_tmoAtMax;
  logic [STARVE_W-1:0] w_starveCntUnused;
  logic [TMO_W-1:0]    w_tmoCntUnused;

  arb_sat_counter #(.WIDTH(STARVE_W), .MAX(STARVE_MAX)) u_starveCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (d_gnt && i_req),
    .clr    (i_gnt || !i_req),
    .cnt    (w_starveCntUnused),
    .at_max (w_starveAtMax)
  );

  // Counts BUSY cycles; reaching TIMEOUT_CYC-1 without a response times out.
  arb_sat_counter #(.WIDTH(TMO_W), .MAX(TIMEOUT_CYC - 1)) u_tmoCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (r_state == ARB_BUSY),
    .clr    (mem_req),
    .cnt    (w_tmoCntUnused),
    .at_max (w_tmoAtMax)
  );

  always_comb begin
    // Grants are gated by rst_n so that nothing leaks out during reset;
    // no grant is issued in the cycle the timeout error is reported.
    w_canGrant  = rst_n && !r_errPend && ((r_state == ARB_IDLE) || mem_rvalid);
    w_fetchWins = i_req && (!d_req || w_starveAtMax);
    i_gnt       = w_canGrant && w_fetchWins;
    d_gnt       = w_canGrant && d_req && !w_fetchWins;
    mem_req     = i_gnt || d_gnt;
    mem_we      = 1'b0;
    mem_be      = 4'h0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_be    = 4'hF;
      mem_addr  = i_addr;
    end

    w_done    = (r_state == ARB_BUSY) && mem_rvalid;
    w_timeout = (r_state == ARB_BUSY) && !mem_rvalid && w_tmoAtMax;

    i_rvalid = (w_done || r_errPend) && (r_owner == OWN_IF);
    i_err    = r_errPend && (r_owner == OWN_IF);
    i_rdata  = (w_done && (r_owner == OWN_IF)) ? mem_rdata : '0;
    d_rvalid = (w_done || r_errPend) && (r_owner == OWN_DM);
    d_err    = r_errPend && (r_owner == OWN_DM);
    d_rdata  = (w_done && (r_owner == OWN_DM) && !r_ownerWe) ? mem_rdata : '0;

    w_nextState   = r_state;
    w_nextOwner   = r_owner;
    w_nextOwnerWe = r_ownerWe;
    w_nextErrPend = 1'b0;
    if (mem_req) begin
      w_nextState   = ARB_BUSY;
      w_nextOwner   = d_gnt ? OWN_DM : OWN_IF;
      w_nextOwnerWe = d_gnt && d_we;
    end else if (w_done) begin
      w_nextState   = ARB_IDLE;
      w_nextOwner   = OWN_NONE;
      w_nextOwnerWe = 1'b0;
    end else if (w_timeout) begin
      w_nextState   = ARB_IDLE;
      w_nextErrPend = 1'b1;
    end else if (r_errPend) begin
      w_nextOwner   = OWN_NONE;
      w_nextOwnerWe = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWN_NONE;
      r_ownerWe <= 1'b0;
      r_errPend <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_owner   <= w_nextOwner;
      r_ownerWe <= w_nextOwnerWe;
      r_errPend <= w_nextErrPend;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: literal checks per scenario plus a
// transaction-level model compared against every output on every cycle.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TCYC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid, i_err;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_be = 4'h0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DAT_WIDTH  (DW),
    .STARVE_MAX (SMAX),
    .TIMEOUT_CYC(TCYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  int checkCount = 0;
  int passCount  = 0;
  bit modelOn    = 1'b0;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic ir, input logic [AW-1:0] ia, input logic dr,
                               input logic dw, input logic [3:0] db, input logic [AW-1:0] da,
                               input logic [DW-1:0] dd, input logic mrv, input logic [DW-1:0] mrd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_be = db;
    d_addr = da; d_wdata = dd; mem_rvalid = mrv; mem_rdata = mrd;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: owner codes 1 = fetch, 2 = data.
  bit mBusy = 1'b0;
  int mOwner = 0;
  bit mWrite = 1'b0;
  int mAge = 0;
  int mErrOwner = 0;
  int mLosses = 0;
  logic eDone, eTmo, eFree, eFetchWins, eIg, eDg;
  logic [139:0] expVec, actVec;

  always @(negedge clk) begin
    if (modelOn) begin
      if (!rst_n) begin
        mBusy = 1'b0; mErrOwner = 0; mLosses = 0; mAge = 0; mOwner = 0;
        expVec = '0;
      end else begin
        eDone      = mBusy && mem_rvalid;
        eTmo       = mBusy && !mem_rvalid && (mAge == TCYC - 1);
        eFree      = (mErrOwner == 0) && (!mBusy || mem_rvalid);
        eFetchWins = i_req && (!d_req || (mLosses >= SMAX));
        eIg        = eFree && eFetchWins;
        eDg        = eFree && d_req && !eFetchWins;
        expVec = {eIg,
                  (eDone && mOwner == 1) || (mErrOwner == 1),
                  (eDone && mOwner == 1) ? mem_rdata : 32'h0,
                  logic'(mErrOwner == 1),
                  eDg,
                  (eDone && mOwner == 2) || (mErrOwner == 2),
                  (eDone && mOwner == 2 && !mWrite) ? mem_rdata : 32'h0,
                  logic'(mErrOwner == 2),
                  eIg || eDg,
                  eDg && d_we,
                  eDg ? d_be : (eIg ? 4'hF : 4'h0),
                  eDg ? d_addr : (eIg ? i_addr : 32'h0),
                  eDg ? d_wdata : 32'h0};
        if (!i_req || eIg) mLosses = 0;
        else if (eDg && mLosses < SMAX) mLosses++;
        mErrOwner = 0;
        if (eDone) mBusy = 1'b0;
        else if (eTmo) begin mBusy = 1'b0; mErrOwner = mOwner; end
        else if (mBusy) mAge++;
        if (eIg || eDg) begin
          mBusy = 1'b1; mOwner = eIg ? 1 : 2; mWrite = eDg && d_we; mAge = 0;
        end
      end
      actVec = {i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
                mem_req, mem_we, mem_be, mem_addr, mem_wdata};
      checkCount++;
      if (actVec === expVec) passCount++;
      else $display("[TB] FAIL model_cycle: got 0x%035h, expected 0x%035h at %0t", actVec, expVec, $time);
    end
  end

  initial begin
    modelOn = 1'b1;
    // Reset: requests must not produce grants while rst_n is low.
    applyStimulus(1, 32'h0, 1, 0, 4'h0, 32'h10, 32'h0, 1, 32'h55);
    checkOutput("reset_i_gnt", i_gnt, 0);
    checkOutput("reset_d_gnt", d_gnt, 0);
    checkOutput("reset_mem_req", mem_req, 0);
    checkOutput("reset_d_rvalid", d_rvalid, 0);
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    nextCycle;

    // Fetch only, memory answers two cycles after the grant.
    applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_i_gnt", i_gnt, 1);
    checkOutput("t1_mem_req", mem_req, 1);
    checkOutput("t1_mem_be", mem_be, 4'hF);
    checkOutput("t1_mem_addr", mem_addr, 32'h0);
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_i_rvalid_early", i_rvalid, 0);
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093);
    checkOutput("t1_i_rvalid", i_rvalid, 1);
    checkOutput("t1_i_rdata", i_rdata, 32'h00500093);
    checkOutput("t1_i_err", i_err, 0);
    nextCycle;

    // Contention: data first, fetch granted back-to-back on data's response.
    applyStimulus(1, 32'h4, 1, 0, 4'h0, 32'h100, 0, 0, 0);
    checkOutput("t2_d_gnt", d_gnt, 1);
    checkOutput("t2_i_gnt", i_gnt, 0);
    checkOutput("t2_mem_addr", mem_addr, 32'h100);
    nextCycle;
    applyStimulus(1, 32'h4, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_busy_i_gnt", i_gnt, 0);
    nextCycle;
    applyStimulus(1, 32'h4, 0, 0, 0, 0, 0, 1, 32'h11111111);
    checkOutput("t2_d_rvalid", d_rvalid, 1);
    checkOutput("t2_d_rdata", d_rdata, 32'h11111111);
    checkOutput("t2_b2b_i_gnt", i_gnt, 1);
    checkOutput("t2_b2b_mem_addr", mem_addr, 32'h4);
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222);
    checkOutput("t2_i_rvalid", i_rvalid, 1);
    checkOutput("t2_i_rdata", i_rdata, 32'h22222222);
    nextCycle;

    // Starvation: four data grants, then fetch takes the fifth.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 32'h8, 1, 0, 4'h0, 32'h100 + 32'(4 * k), 0, k > 0, 32'hA0 + 32'(k));
      checkOutput($sformatf("t3_d_gnt_%0d", k), d_gnt, (k < 4) ? 1 : 0);
      checkOutput($sformatf("t3_i_gnt_%0d", k), i_gnt, (k == 4) ? 1 : 0);
      nextCycle;
    end
    applyStimulus(1, 32'h8, 1, 0, 4'h0, 32'h200, 0, 1, 32'hA5);
    checkOutput("t3_cleared_d_gnt", d_gnt, 1);
    checkOutput("t3_i_rvalid", i_rvalid, 1);
    checkOutput("t3_i_rdata", i_rdata, 32'hA5);
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hA6);
    checkOutput("t3_d_rvalid", d_rvalid, 1);
    nextCycle;

    // Write: acknowledged with zero read data.
    applyStimulus(0, 0, 1, 1, 4'b0011, 32'h200, 32'hDEADBEEF, 0, 0);
    checkOutput("t4_mem_we", mem_we, 1);
    checkOutput("t4_mem_be", mem_be, 4'b0011);
    checkOutput("t4_mem_wdata", mem_wdata, 32'hDEADBEEF);
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
    checkOutput("t4_d_rvalid", d_rvalid, 1);
    checkOutput("t4_d_rdata", d_rdata, 32'h0);
    nextCycle;

    // Timeout: error pulse after TCYC silent BUSY cycles, late response ignored.
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h300, 0, 0, 0);
    checkOutput("t5_d_gnt", d_gnt, 1);
    for (int c = 1; c <= TCYC; c++) begin
      nextCycle;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("t5_quiet_%0d", c), d_rvalid, 0);
    end
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_d_rvalid", d_rvalid, 1);
    checkOutput("t5_d_err", d_err, 1);
    checkOutput("t5_d_rdata", d_rdata, 32'h0);
    nextCycle;
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hFEED);
    checkOutput("t5_late_d_rvalid", d_rvalid, 0);
    checkOutput("t5_late_i_rvalid", i_rvalid, 0);
    nextCycle;

    // Response in the last cycle before timeout completes normally.
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h304, 0, 0, 0);
    for (int c = 1; c < TCYC; c++) begin
      nextCycle;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
    checkOutput("t5b_d_rvalid", d_rvalid, 1);
    checkOutput("t5b_d_err", d_err, 0);
    checkOutput("t5b_d_rdata", d_rdata, 32'h77);
    nextCycle;

    // Reset while BUSY: transaction dropped, stale response ignored.
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_i_gnt", i_gnt, 1);
    nextCycle;
    rst_n = 1'b0;
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h20, 0, 1, 32'hBAD);
    checkOutput("t6_rst_d_gnt", d_gnt, 0);
    checkOutput("t6_rst_mem_req", mem_req, 0);
    checkOutput("t6_rst_i_rvalid", i_rvalid, 0);
    nextCycle;
    rst_n = 1'b1;
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 1, 32'hBAD);
    checkOutput("t6_idle_i_gnt", i_gnt, 1);
    checkOutput("t6_stale_i_rvalid", i_rvalid, 0);
    checkOutput("t6_mem_addr", mem_addr, 32'h80);
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h600D);
    checkOutput("t6_i_rvalid", i_rvalid, 1);
    checkOutput("t6_i_rdata", i_rdata, 32'h600D);
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle;
    modelOn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
